// File: rtl/block_interleaver_pp_if.sv
// Stream handshake bundle for block_interleaver_pp.
// master drives symbols in and accepts them out; slave is the interleaver.
interface block_interleaver_pp_if #(
  parameter int WIDTH = 1
);
  logic             mode;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_sop;
  logic             dout_eop;

  modport master (
    output mode,
    output din,
    output din_valid,
    input  din_ready,
    input  dout,
    input  dout_valid,
    output dout_ready,
    input  dout_sop,
    input  dout_eop
  );

  modport slave (
    input  mode,
    input  din,
    input  din_valid,
    output din_ready,
    output dout,
    output dout_valid,
    input  dout_ready,
    output dout_sop,
    output dout_eop
  );
endinterface

// File: rtl/block_interleaver_pp.sv
// Row/column block (de)interleaver with ping-pong banks.
// One bank fills linearly while the other is read in permuted order.
module block_interleaver_pp #(
  parameter int WIDTH = 1,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
) (
  input  logic                 clk2,
  input  logic                 rst,
  block_interleaver_pp_if.slave bus
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  localparam logic [AW-1:0] A_LAST = AW'(N - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

  logic [WIDTH-1:0] mem [2][N];

  logic [1:0]       full;
  logic [1:0]       bank_mode;
  logic             wr_bank;
  logic             rd_bank;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [RW-1:0]    r_idx;
  logic [CW-1:0]    c_idx;
  logic [RW-1:0]    r_nxt;
  logic [CW-1:0]    c_nxt;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             sop_q;
  logic             eop_q;

  logic wr_fire;
  logic wr_last;
  logic rd_mode;
  logic rd_load;
  logic rd_first;
  logic rd_last;
  logic r_wrap;
  logic c_wrap;

  assign bus.din_ready  = !full[wr_bank];
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.dout_sop   = sop_q;
  assign bus.dout_eop   = eop_q;

  assign wr_fire  = bus.din_valid && !full[wr_bank];
  assign wr_last  = wr_fire && (wr_addr == A_LAST);
  assign rd_mode  = bank_mode[rd_bank];
  assign rd_load  = full[rd_bank] && (!valid_q || bus.dout_ready);
  assign r_wrap   = (r_idx == R_LAST);
  assign c_wrap   = (c_idx == C_LAST);
  assign rd_first = (r_idx == '0) && (c_idx == '0);
  assign rd_last  = r_wrap && c_wrap;

  // mode 0 walks columns outer / rows inner; mode 1 is the transpose
  always_comb begin
    rd_addr = '0;
    unique case (1'b1)
      !rd_mode:
        rd_addr = AW'(int'(r_idx) * COLS + int'(c_idx));
      rd_mode:
        rd_addr = AW'(int'(c_idx) * ROWS + int'(r_idx));
    endcase
  end

  always_comb begin
    r_nxt = r_idx;
    c_nxt = c_idx;
    unique case (1'b1)
      !rd_mode: begin
        r_nxt = r_wrap ? '0 : r_idx + RW'(1);
        if (r_wrap)
          c_nxt = c_wrap ? '0 : c_idx + CW'(1);
      end
      rd_mode: begin
        c_nxt = c_wrap ? '0 : c_idx + CW'(1);
        if (c_wrap)
          r_nxt = r_wrap ? '0 : r_idx + RW'(1);
      end
    endcase
  end

  always_ff @(posedge clk2) begin
    if (wr_fire)
      mem[wr_bank][wr_addr] <= bus.din;
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      full      <= '0;
      bank_mode <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_addr   <= '0;
      r_idx     <= '0;
      c_idx     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_addr == '0)
          bank_mode[wr_bank] <= bus.mode;
        if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_addr       <= '0;
        end else begin
          wr_addr <= wr_addr + AW'(1);
        end
      end
      // write and drain always target different banks
      if (rd_load) begin
        dout_q  <= mem[rd_bank][rd_addr];
        valid_q <= 1'b1;
        sop_q   <= rd_first;
        eop_q   <= rd_last;
        r_idx   <= r_nxt;
        c_idx   <= c_nxt;
        if (rd_last) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end else if (bus.dout_ready) begin
        valid_q <= 1'b0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
      end
    end
  end

endmodule
